dmem_pipe: RTL and testbench

- Parametrised, latency-configurable data memory for the TinyRV1 multi-cycle and pipelined processors.
- Successor to the fixed single-cycle combinational dmem port.
- Accepts one read/write request per cycle over a val/rdy handshake.
- Returns in-order responses after a fixed LATENCY, with backpressure and a bounded number of outstanding requests.
- Sits between processor dmem port and test bench; processor and memory tests share it.

---
 rtl/dmem_pipe_pkg.sv | 27 ++
 rtl/dmem_pipe_if.sv | 32 +++
 rtl/dmem_resp_fifo.sv | 61 ++++++
 rtl/dmem_pipe.sv | 125 ++++++++++++
 tb/tb_dmem_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pipe_pkg.sv
// dmem_pipe shared types: request kind, response bundle
// and the byte-address legality check.
package dmem_pipe_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_e;

    typedef struct packed {
        mem_req_type_e rtype;
        logic [31:0]   rdata;
        logic          err;
    } mem_resp_t;

    localparam int RESP_W = $bits(mem_resp_t);

    // word-aligned and inside the array
    function automatic logic word_index_ok(
        input logic [31:0] addr,
        input int unsigned num_words
    );
        return (addr[1:0] == 2'b00) &&
               ({2'b00, addr[31:2]} < num_words);
    endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// dmem_pipe request/response bus with val/rdy handshakes.
// master = processor/test side, slave = memory side.
interface dmem_pipe_if;
    import dmem_pipe_pkg::*;

    logic          req_val;
    logic          req_rdy;
    mem_req_type_e req_type;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;

    logic          resp_val;
    logic          resp_rdy;
    mem_req_type_e resp_type;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    modport master (
        output req_val, req_type, req_addr, req_wdata,
        output resp_rdy,
        input  req_rdy,
        input  resp_val, resp_type, resp_rdata, resp_err
    );

    modport slave (
        input  req_val, req_type, req_addr, req_wdata,
        input  resp_rdy,
        output req_rdy,
        output resp_val, resp_type, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_resp_fifo.sv
// Synchronous response FIFO, head visible on rdata.
// No bypass: a push into an empty FIFO shows next cycle.
module dmem_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                cnt <= cnt + CW'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/dmem_pipe.sv
// Latency-configurable TinyRV1 data memory, in-order responses.
// Optional write trace ports: define DMEM_PIPE_TRACE_EN.
module dmem_pipe
    import dmem_pipe_pkg::*;
#(
    parameter int NUM_WORDS    = 256,
    parameter int LATENCY      = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    dmem_pipe_if.slave  bus
`ifdef DMEM_PIPE_TRACE_EN
    ,
    output logic        trace_val,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
`endif
);

    localparam int IW = $clog2(NUM_WORDS);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [31:0]   mem [NUM_WORDS];
    logic          accept;
    logic          pop;
    logic          addr_ok;
    logic          is_wr;
    logic          wr_ok;
    logic [IW-1:0] idx;
    mem_resp_t     s0;

    logic [LATENCY-1:0] pipe_val;
    mem_resp_t          pipe_q [LATENCY];

    mem_resp_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] cnt;

    assign accept  = bus.req_val && bus.req_rdy;
    assign pop     = bus.resp_val && bus.resp_rdy;
    assign addr_ok = word_index_ok(bus.req_addr, NUM_WORDS);
    assign is_wr   = (bus.req_type == MEM_WRITE);
    assign wr_ok   = accept && addr_ok && is_wr;
    assign idx     = bus.req_addr[IW+1:2];

    // count covers pipeline plus FIFO, so the FIFO cannot overflow
    assign bus.req_rdy = (cnt < CW'(MAX_INFLIGHT)) && !fifo_full;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[idx] <= bus.req_wdata;
    end

    always_comb begin
        s0.rtype = bus.req_type;
        s0.err   = !addr_ok;
        s0.rdata = (addr_ok && !is_wr) ? mem[idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_val <= '0;
            for (int i = 0; i < LATENCY; i++)
                pipe_q[i] <= '0;
        end else begin
            pipe_val[0] <= accept;
            if (accept)
                pipe_q[0] <= s0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_val[i] <= pipe_val[i-1];
                pipe_q[i]   <= pipe_q[i-1];
            end
        end
    end

    dmem_resp_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (RESP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_val[LATENCY-1]),
        .wdata (pipe_q[LATENCY-1]),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // outputs held at zero while nothing is pending
    always_comb begin
        bus.resp_val   = !fifo_empty;
        bus.resp_type  = fifo_empty ? MEM_READ : head.rtype;
        bus.resp_rdata = fifo_empty ? '0 : head.rdata;
        bus.resp_err   = fifo_empty ? 1'b0 : head.err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (accept && !pop)
            cnt <= cnt + CW'(1);
        else if (pop && !accept)
            cnt <= cnt - CW'(1);
    end

`ifdef DMEM_PIPE_TRACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_val  <= 1'b0;
            trace_addr <= '0;
            trace_data <= '0;
        end else begin
            trace_val <= wr_ok;
            if (wr_ok) begin
                trace_addr <= bus.req_addr;
                trace_data <= bus.req_wdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: NUM_WORDS=256, LATENCY=2,
// MAX_INFLIGHT=4. Inputs driven and outputs sampled on negedge.
module tb_dmem_pipe;
    import dmem_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];

    dmem_pipe_if bus();

`ifdef DMEM_PIPE_TRACE_EN
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
`endif

    dmem_pipe #(
        .NUM_WORDS    (256),
        .LATENCY      (2),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_PIPE_TRACE_EN
        ,
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // called at a negedge; returns at the negedge after acceptance
    task automatic issue(input mem_req_type_e t,
                         input logic [31:0] a,
                         input logic [31:0] d);
        int n;
        n = 0;
        while (!bus.req_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout addr=%h rdy=%b exp=1",
                     a, bus.req_rdy);
        end
        bus.req_val   = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        bus.req_val = 1'b0;
    endtask

    task automatic wait_resp(output bit got,
                             output mem_req_type_e t,
                             output logic [31:0] d,
                             output logic e);
        got = 1'b0;
        t   = MEM_READ;
        d   = '0;
        e   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.resp_val) begin
                got = 1'b1;
                t   = bus.resp_type;
                d   = bus.resp_rdata;
                e   = bus.resp_err;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_rdy got=%b exp=1", bus.req_rdy);
        end
        checks++;
        if (bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp_val got=%b exp=0", bus.resp_val);
        end
        checks++;
        if ({bus.resp_type, bus.resp_rdata, bus.resp_err} !== 34'h0) begin
            errors++;
            $display("FAIL rst_resp_fields got=%b/%h/%b exp=0/0/0",
                     bus.resp_type, bus.resp_rdata, bus.resp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_rdy !== 1'b1 || bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got rdy=%b val=%b exp 1/0",
                     bus.req_rdy, bus.resp_val);
        end
    endtask

    task automatic test_basic_read;
        issue(MEM_WRITE, 32'h40, 32'hdeadbeef);
        issue(MEM_WRITE, 32'h0, 32'h11111111);
        issue(MEM_WRITE, 32'h3fc, 32'hcafef00d);
        idle(6);
        issue(MEM_READ, 32'h40, 32'h0);
        checks++;
        if (bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL lat_plus1 got=%b exp=0", bus.resp_val);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL lat_plus2_early got=%b exp=0", bus.resp_val);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_val !== 1'b1 || bus.resp_rdata !== 32'hdeadbeef ||
            bus.resp_err !== 1'b0 || bus.resp_type !== MEM_READ) begin
            errors++;
            $display("FAIL basic_read got val=%b d=%h e=%b exp 1/deadbeef/0",
                     bus.resp_val, bus.resp_rdata, bus.resp_err);
        end
    endtask

    task automatic test_write_read;
        bit            got;
        mem_req_type_e t;
        logic [31:0]   d;
        logic          e;
        issue(MEM_WRITE, 32'h84, 32'h2000);
        issue(MEM_READ, 32'h84, 32'h0);
        wait_resp(got, t, d, e);
        checks++;
        if (!got || t !== MEM_WRITE || d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got=%b t=%b d=%h e=%b exp 1/1/0/0",
                     got, t, d, e);
        end
        wait_resp(got, t, d, e);
        checks++;
        if (!got || t !== MEM_READ || d !== 32'h2000 || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_after_wr got=%b t=%b d=%h e=%b exp 1/0/2000/0",
                     got, t, d, e);
        end
    endtask

    task automatic test_errors;
        bit            got;
        mem_req_type_e t;
        logic [31:0]   d;
        logic          e;
        issue(MEM_READ, 32'h41, 32'h0);
        wait_resp(got, t, d, e);
        checks++;
        if (!got || t !== MEM_READ || d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned got=%b t=%b d=%h e=%b exp 1/0/0/1",
                     got, t, d, e);
        end
        issue(MEM_WRITE, 32'h400, 32'h00000bad);
        wait_resp(got, t, d, e);
        checks++;
        if (!got || t !== MEM_WRITE || d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range got=%b t=%b d=%h e=%b exp 1/1/0/1",
                     got, t, d, e);
        end
        issue(MEM_READ, 32'h0, 32'h0);
        wait_resp(got, t, d, e);
        checks++;
        if (!got || d !== 32'h11111111 || e !== 1'b0) begin
            errors++;
            $display("FAIL word0_kept got=%b d=%h e=%b exp 1/11111111/0",
                     got, d, e);
        end
        issue(MEM_READ, 32'h3fc, 32'h0);
        wait_resp(got, t, d, e);
        checks++;
        if (!got || d !== 32'hcafef00d || e !== 1'b0) begin
            errors++;
            $display("FAIL last_word got=%b d=%h e=%b exp 1/cafef00d/0",
                     got, d, e);
        end
    endtask

    task automatic test_backpressure;
        int acc;
        bit will;
        idle(2);
        bus.resp_rdy = 1'b0;
        bus.req_type = MEM_READ;
        bus.req_val  = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            will = bus.req_rdy;
            bus.req_addr = (acc < 4) ? addrs[acc] : 32'h40;
            @(negedge clk);
            if (will)
                acc++;
        end
        bus.req_val = 1'b0;
        checks++;
        if (acc != 4 || bus.req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts got=%0d rdy=%b exp 4/0",
                     acc, bus.req_rdy);
        end
        bus.resp_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (bus.resp_val !== 1'b1 || bus.resp_rdata !== exp_d[j] ||
                bus.resp_type !== MEM_READ) begin
                errors++;
                $display("FAIL bp_drain%0d got val=%b d=%h exp 1/%h",
                         j, bus.resp_val, bus.resp_rdata, exp_d[j]);
            end
            if (j < 2) begin
                checks++;
                if (bus.req_rdy !== (j == 1)) begin
                    errors++;
                    $display("FAIL bp_rdy%0d got=%b exp=%b",
                             j, bus.req_rdy, (j == 1));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got=%b exp=0", bus.resp_val);
        end
    endtask

    task automatic test_back_to_back;
        bit expv;
        bus.resp_rdy = 1'b1;
        bus.req_type = MEM_READ;
        for (int k = 0; k < 21; k++) begin
            expv = (k >= 3) && (k <= 18);
            checks++;
            if (bus.resp_val !== expv) begin
                errors++;
                $display("FAIL b2b_val%0d got=%b exp=%b",
                         k, bus.resp_val, expv);
            end
            if (expv) begin
                checks++;
                if (bus.resp_rdata !== exp_d[(k-3)%4]) begin
                    errors++;
                    $display("FAIL b2b_data%0d got=%h exp=%h",
                             k, bus.resp_rdata, exp_d[(k-3)%4]);
                end
            end
            if (k < 16) begin
                checks++;
                if (bus.req_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rdy%0d got=%b exp=1",
                             k, bus.req_rdy);
                end
                bus.req_val  = 1'b1;
                bus.req_addr = addrs[k%4];
            end else begin
                bus.req_val = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        bit            stale;
        bit            got;
        mem_req_type_e t;
        logic [31:0]   d;
        logic          e;
        bus.resp_rdy = 1'b0;
        issue(MEM_READ, 32'h40, 32'h0);
        issue(MEM_READ, 32'h84, 32'h0);
        issue(MEM_READ, 32'h0, 32'h0);
        checks++;
        if (bus.resp_val !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending got=%b exp=1", bus.resp_val);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.resp_val !== 1'b0 || bus.req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_async got val=%b rdy=%b exp 0/1",
                     bus.resp_val, bus.req_rdy);
        end
        idle(2);
        rst = 1'b1;
        bus.resp_rdy = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_val !== 1'b0)
                stale = 1'b1;
        end
        checks++;
        if (stale || bus.req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_stale got stale=%b rdy=%b exp 0/1",
                     stale, bus.req_rdy);
        end
        issue(MEM_READ, 32'h84, 32'h0);
        wait_resp(got, t, d, e);
        checks++;
        if (!got || d !== 32'h2000 || e !== 1'b0) begin
            errors++;
            $display("FAIL mid_retain got=%b d=%h e=%b exp 1/2000/0",
                     got, d, e);
        end
    endtask

    initial begin
        addrs[0] = 32'h40;  exp_d[0] = 32'hdeadbeef;
        addrs[1] = 32'h84;  exp_d[1] = 32'h00002000;
        addrs[2] = 32'h0;   exp_d[2] = 32'h11111111;
        addrs[3] = 32'h3fc; exp_d[3] = 32'hcafef00d;
        bus.req_val   = 1'b0;
        bus.req_type  = MEM_READ;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.resp_rdy  = 1'b1;
        #1;
        test_reset;
        test_basic_read;
        test_write_read;
        test_errors;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
